// File: rtl/alexnet_pkg.sv
// Shared definitions for the AlexNet activation datapath.
//   DATA_W          : activation width (signed two's complement)
//   CONV*_FMAP      : square feature-map edge length per conv layer
//   act_t           : one activation word
//   row_cls_t       : role of an input row inside a 3-row pooling window
//   max_s()         : signed maximum of two activations, shared by all pooling stages
package alexnet_pkg;

   localparam int DATA_W     = 23;
   localparam int CONV1_FMAP = 55;
   localparam int CONV2_FMAP = 27;
   localparam int CONV5_FMAP = 13;

   typedef logic signed [DATA_W-1:0] act_t;

   // ROW_FIRST : row 0, seeds the running column maxima
   // ROW_ODD   : middle row of a window, folds into the running maxima
   // ROW_EVEN  : row >= 2, closes a window and seeds the next one
   typedef enum logic [1:0] {
      ROW_FIRST = 2'd0,
      ROW_ODD   = 2'd1,
      ROW_EVEN  = 2'd2
   } row_cls_t;

   // Signed maximum; on a tie either operand carries the same value.
   function automatic act_t max_s(input act_t a, input act_t b);
      act_t m;
      if (a > b) begin
         m = a;
      end else begin
         m = b;
      end
      return m;
   endfunction

endpackage

// File: rtl/max_pool_3s2_if.sv
// Activation stream between the ReLU stage and the 3x3/stride-2 pooling stage.
//   en    : input pixel valid (ReLU write)
//   in    : input activation (ReLU out)
//   out   : pooled activation
//   write : out valid, one-cycle pulse per pooled result
//   done  : one-cycle pulse marking the end of an input frame
// master drives the pixel stream and observes results; slave is the pooling stage.
interface max_pool_3s2_if #(
   parameter int DATA_W = alexnet_pkg::DATA_W
) ();

   logic              en;
   logic [DATA_W-1:0] in;
   logic [DATA_W-1:0] out;
   logic              write;
   logic              done;

   modport master (
      output en,
      output in,
      input  out,
      input  write,
      input  done
   );

   modport slave (
      input  en,
      input  in,
      output out,
      output write,
      output done
   );

endinterface

// File: rtl/pool_row_buf.sv
// Running row-max buffer: one entry per output column.
//   clk   : clock, write on rising edge
//   we    : write enable
//   idx   : output column index, shared by read and write
//   wdata : value written at idx when we is high
//   rdata : combinational read of entry idx
// Entries carry no reset: every entry is written on row 0 of a frame before it is read.
module pool_row_buf
   import alexnet_pkg::*;
#(
   parameter int DEPTH = 27,
   parameter int WIDTH = DATA_W,
   parameter int IDX_W = 5
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] idx,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   assign rdata = mem[idx];

   // Synchronous write port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wdata;
      end
   end

endmodule

// File: rtl/max_pool_3s2.sv
// Streaming 3x3, stride-2 max pooling over a raster-ordered activation stream.
//   clk        : clock
//   rst        : synchronous active-high reset
//   bus.en     : input pixel valid
//   bus.in     : input activation
//   bus.out    : pooled activation (registered)
//   bus.write  : bus.out valid, one-cycle pulse
//   bus.done   : end-of-frame pulse, two cycles after the last pixel is accepted
// Pipeline: the accepting cycle registers the horizontal 3-max, output column and row
// class; the next cycle does the row-buffer read-modify-write and registers the result.
module max_pool_3s2
   import alexnet_pkg::*;
#(
   parameter int DATA_W = alexnet_pkg::DATA_W,
   parameter int IN_W   = alexnet_pkg::CONV1_FMAP,
   parameter int IN_H   = alexnet_pkg::CONV1_FMAP
) (
   input  logic           clk,
   input  logic           rst,
   max_pool_3s2_if.slave  bus
);

   localparam int OUT_W = (IN_W - 3) / 2 + 1;
   localparam int COL_W = (IN_W > 1)  ? $clog2(IN_W)  : 1;
   localparam int ROW_W = (IN_H > 1)  ? $clog2(IN_H)  : 1;
   localparam int OC_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_H - 1);

   typedef logic signed [DATA_W-1:0] word_t;

   // Position of the next accepted pixel.
   logic [COL_W-1:0] col_r;
   logic [ROW_W-1:0] row_r;

   // Previous two accepted pixels: p1 is column col-1, p2 is column col-2.
   word_t p1_r;
   word_t p2_r;

   // Decode of the pixel currently on the bus.
   logic             close_s;
   logic [OC_W-1:0]  oc_s;
   row_cls_t         cls_s;
   logic             last_s;
   word_t            hmax_s;

   // Stage-1 registers.
   logic             s1_valid_r;
   logic             s1_close_r;
   logic             s1_last_r;
   logic [OC_W-1:0]  s1_oc_r;
   row_cls_t         s1_cls_r;
   word_t            s1_hmax_r;

   // Row-buffer access and vertical combine.
   logic             vb_we_s;
   word_t            vb_wdata_s;
   logic [DATA_W-1:0] vb_rd_s;
   word_t            vmax_s;
   logic             emit_s;

   // Output registers.
   logic [DATA_W-1:0] out_r;
   logic              write_r;
   logic              done_r;

   // Window-close detection, output column, row class and horizontal 3-max.
   always_comb begin
      close_s = 1'b0;
      cls_s   = ROW_FIRST;
      last_s  = 1'b0;
      hmax_s  = max_s(max_s(p2_r, p1_r), bus.in);
      // Wraps for col < 2, but close_s is low there so the index is never used.
      oc_s    = OC_W'((col_r - COL_W'(2)) >> 1);

      if ((col_r >= COL_W'(2)) && (col_r[0] == 1'b0)) begin
         close_s = 1'b1;
      end else begin
         close_s = 1'b0;
      end

      if (row_r == ROW_W'(0)) begin
         cls_s = ROW_FIRST;
      end else if (row_r[0] == 1'b1) begin
         cls_s = ROW_ODD;
      end else begin
         cls_s = ROW_EVEN;
      end

      if ((col_r == COL_LAST) && (row_r == ROW_LAST)) begin
         last_s = 1'b1;
      end else begin
         last_s = 1'b0;
      end
   end

   // Raster counters; both wrap after the last pixel so the next frame follows directly.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_r <= {COL_W{1'b0}};
         row_r <= {ROW_W{1'b0}};
      end else if (bus.en) begin
         if (col_r == COL_LAST) begin
            col_r <= {COL_W{1'b0}};
            if (row_r == ROW_LAST) begin
               row_r <= {ROW_W{1'b0}};
            end else begin
               row_r <= row_r + ROW_W'(1);
            end
         end else begin
            col_r <= col_r + COL_W'(1);
         end
      end
   end

   // Horizontal history; a window only closes at col >= 2, so stale values from
   // the previous row are never consumed.
   always_ff @(posedge clk) begin
      if (bus.en) begin
         p2_r <= p1_r;
         p1_r <= bus.in;
      end
   end

   // Stage-1 valid bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
      end else begin
         s1_valid_r <= bus.en;
      end
   end

   // Stage-1 payload, only meaningful while s1_valid_r is high.
   always_ff @(posedge clk) begin
      if (bus.en) begin
         s1_close_r <= close_s;
         s1_last_r  <= last_s;
         s1_oc_r    <= oc_s;
         s1_cls_r   <= cls_s;
         s1_hmax_r  <= hmax_s;
      end
   end

   pool_row_buf #(
      .DEPTH (OUT_W),
      .WIDTH (DATA_W),
      .IDX_W (OC_W)
   ) u_vbuf (
      .clk   (clk),
      .we    (vb_we_s),
      .idx   (s1_oc_r),
      .wdata (vb_wdata_s),
      .rdata (vb_rd_s)
   );

   // Vertical combine: seed, fold or emit depending on the row role.
   always_comb begin
      vb_we_s    = 1'b0;
      vb_wdata_s = s1_hmax_r;
      vmax_s     = max_s(vb_rd_s, s1_hmax_r);
      emit_s     = 1'b0;
      if (s1_valid_r && s1_close_r) begin
         case (s1_cls_r)
            ROW_FIRST: begin
               vb_we_s    = 1'b1;
               vb_wdata_s = s1_hmax_r;
            end
            ROW_ODD: begin
               vb_we_s    = 1'b1;
               vb_wdata_s = vmax_s;
            end
            ROW_EVEN: begin
               // The closing row is also the top row of the next window.
               vb_we_s    = 1'b1;
               vb_wdata_s = s1_hmax_r;
               emit_s     = 1'b1;
            end
            default: begin
               vb_we_s    = 1'b0;
               vb_wdata_s = s1_hmax_r;
               emit_s     = 1'b0;
            end
         endcase
      end else begin
         vb_we_s = 1'b0;
         emit_s  = 1'b0;
      end
   end

   // Registered outputs; out holds its last result between pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_r   <= {DATA_W{1'b0}};
         write_r <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         write_r <= emit_s;
         done_r  <= s1_valid_r && s1_last_r;
         if (emit_s) begin
            out_r <= vmax_s;
         end
      end
   end

   assign bus.out   = out_r;
   assign bus.write = write_r;
   assign bus.done  = done_r;

endmodule

// File: tb/tb_max_pool_3s2.sv
// Bench for max_pool_3s2: two instances (5x5 and 6x6). A reference model computes
// each pooled value directly from the frame as a 3x3 maximum and schedules it two
// cycles after its closing pixel; one process drives stimulus and compares every cycle.
module tb_max_pool_3s2;

   localparam int DW = 23;

   typedef struct {
      int            tag;
      logic [DW-1:0] val;
   } exp_t;

   logic clk;
   logic rst;
   int   ecount;
   int   nvec;
   int   nfail;
   bit   chk_on;

   exp_t          exp5[$];
   exp_t          exp6[$];
   int            dq5[$];
   int            dq6[$];
   logic [DW-1:0] got5[$];
   logic [DW-1:0] got6[$];
   int            wedge5[$];
   int            wedge6[$];
   int            dedge5[$];
   int            dedge6[$];
   int            lit_q[$];
   int            px22_edge;
   int            last_edge;
   logic signed [DW-1:0] pix [0:63];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) ecount <= ecount + 1;

   max_pool_3s2_if #(.DATA_W(DW)) bus5 ();
   max_pool_3s2_if #(.DATA_W(DW)) bus6 ();

   max_pool_3s2 #(.DATA_W(DW), .IN_W(5), .IN_H(5)) dut5 (
      .clk (clk),
      .rst (rst),
      .bus (bus5.slave)
   );

   max_pool_3s2 #(.DATA_W(DW), .IN_W(6), .IN_H(6)) dut6 (
      .clk (clk),
      .rst (rst),
      .bus (bus6.slave)
   );

   task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] want);
      nvec++;
      if (got !== want) begin
         nfail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, ecount, got, want);
      end
   endtask

   // Reference 3x3 maximum of output (orow, ocol) over a frame of width w.
   function automatic logic [DW-1:0] pool_ref(input int w, input int orow, input int ocol);
      logic signed [DW-1:0] m;
      m = pix[(2 * orow) * w + 2 * ocol];
      for (int dr = 0; dr < 3; dr++) begin
         for (int dc = 0; dc < 3; dc++) begin
            if (pix[(2 * orow + dr) * w + 2 * ocol + dc] > m) begin
               m = pix[(2 * orow + dr) * w + 2 * ocol + dc];
            end
         end
      end
      return m;
   endfunction

   task automatic check_cycle();
      logic ew;
      logic ed;
      if (chk_on) begin
         ew = (exp5.size() > 0) && (exp5[0].tag == ecount);
         cmp("write5", 32'(bus5.write), 32'(ew));
         if (ew) begin
            cmp("out5", 32'(bus5.out), 32'(exp5[0].val));
            void'(exp5.pop_front());
         end
         ed = (dq5.size() > 0) && (dq5[0] == ecount);
         cmp("done5", 32'(bus5.done), 32'(ed));
         if (ed) void'(dq5.pop_front());

         ew = (exp6.size() > 0) && (exp6[0].tag == ecount);
         cmp("write6", 32'(bus6.write), 32'(ew));
         if (ew) begin
            cmp("out6", 32'(bus6.out), 32'(exp6[0].val));
            void'(exp6.pop_front());
         end
         ed = (dq6.size() > 0) && (dq6[0] == ecount);
         cmp("done6", 32'(bus6.done), 32'(ed));
         if (ed) void'(dq6.pop_front());

         if (bus5.write === 1'b1) begin
            got5.push_back(bus5.out);
            wedge5.push_back(ecount);
         end
         if (bus6.write === 1'b1) begin
            got6.push_back(bus6.out);
            wedge6.push_back(ecount);
         end
         if (bus5.done === 1'b1) dedge5.push_back(ecount);
         if (bus6.done === 1'b1) dedge6.push_back(ecount);
      end
   endtask

   // One clock: check outputs at the falling edge, then drive the next input.
   task automatic step(input int which, input logic e, input logic [DW-1:0] v);
      @(negedge clk);
      check_cycle();
      bus5.en = (which == 5) ? e : 1'b0;
      bus5.in = v;
      bus6.en = (which == 6) ? e : 1'b0;
      bus6.in = v;
   endtask

   task automatic drain();
      for (int i = 0; i < 4; i++) step(0, 1'b0, '0);
   endtask

   task automatic feed_frame(input int which, input int w, input int h, input int gap_max);
      int   g;
      exp_t e;
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            for (int i = 0; i < g; i++) step(which, 1'b0, '0);
            step(which, 1'b1, pix[r * w + c]);
            if (r == 2 && c == 2) px22_edge = ecount;
            if (r >= 2 && c >= 2 && (r % 2) == 0 && (c % 2) == 0) begin
               e.tag = ecount + 2;
               e.val = pool_ref(w, r / 2 - 1, c / 2 - 1);
               if (which == 5) exp5.push_back(e);
               else exp6.push_back(e);
            end
            if (r == h - 1 && c == w - 1) begin
               last_edge = ecount;
               if (which == 5) dq5.push_back(ecount + 2);
               else dq6.push_back(ecount + 2);
            end
         end
      end
   endtask

   task automatic pulse_reset();
      step(0, 1'b0, '0);
      rst = 1'b1;
      exp5.delete();
      exp6.delete();
      dq5.delete();
      dq6.delete();
      step(0, 1'b0, '0);
      cmp("reset out5", 32'(bus5.out), 32'd0);
      cmp("reset write5", 32'(bus5.write), 32'd0);
      cmp("reset done5", 32'(bus5.done), 32'd0);
      rst = 1'b0;
   endtask

   task automatic clear_logs();
      got5.delete();
      got6.delete();
      wedge5.delete();
      wedge6.delete();
      dedge5.delete();
      dedge6.delete();
      lit_q.delete();
   endtask

   task automatic add4(input int a, input int b, input int c, input int d);
      lit_q.push_back(a);
      lit_q.push_back(b);
      lit_q.push_back(c);
      lit_q.push_back(d);
   endtask

   // Compare the captured results of one instance with the hand-computed list.
   task automatic check_list(input string nm, input int which);
      logic [DW-1:0] g[$];
      if (which == 5) g = got5;
      else g = got6;
      cmp({nm, " write count"}, 32'(g.size()), 32'(lit_q.size()));
      for (int i = 0; i < lit_q.size(); i++) begin
         cmp({nm, " value"}, (i < g.size()) ? 32'(g[i]) : 32'hFFFF_FFFF, 32'(lit_q[i]));
      end
   endtask

   task automatic ramp(input int w);
      for (int i = 0; i < 64; i++) pix[i] = DW'(i);
      // Raster index r*w+c is the ramp value for every width.
      if (w == 0) pix[0] = '0;
   endtask

   initial begin
      rst     = 1'b1;
      bus5.en = 1'b0;
      bus5.in = '0;
      bus6.en = 1'b0;
      bus6.in = '0;

      // Reset state.
      step(0, 1'b0, '0);
      step(0, 1'b0, '0);
      cmp("init out5", 32'(bus5.out), 32'd0);
      cmp("init write5", 32'(bus5.write), 32'd0);
      cmp("init done5", 32'(bus5.done), 32'd0);
      cmp("init out6", 32'(bus6.out), 32'd0);
      cmp("init write6", 32'(bus6.write), 32'd0);
      cmp("init done6", 32'(bus6.done), 32'd0);
      rst    = 1'b0;
      chk_on = 1'b1;

      // 5x5 ramp, continuous.
      ramp(5);
      clear_logs();
      add4(12, 14, 22, 24);
      feed_frame(5, 5, 5, 0);
      drain();
      check_list("ramp5", 5);
      cmp("ramp5 first-write latency", (wedge5.size() > 0) ? 32'(wedge5[0] - px22_edge) : 32'hFFFF_FFFF, 32'd2);
      cmp("ramp5 done count", 32'(dedge5.size()), 32'd1);
      cmp("ramp5 done cycle", (dedge5.size() > 0) ? 32'(dedge5[0]) : 32'hFFFF_FFFF, 32'(last_edge + 2));
      cmp("ramp5 last write cycle", (wedge5.size() == 4) ? 32'(wedge5[3]) : 32'hFFFF_FFFF, 32'(last_edge + 2));

      // 5x5 ramp with idle gaps.
      clear_logs();
      add4(12, 14, 22, 24);
      feed_frame(5, 5, 5, 3);
      drain();
      check_list("gapped5", 5);
      cmp("gapped5 done count", 32'(dedge5.size()), 32'd1);

      // 6x6 ramp: last column and row are discarded.
      ramp(6);
      clear_logs();
      add4(14, 16, 26, 28);
      feed_frame(6, 6, 6, 0);
      drain();
      check_list("even6", 6);
      cmp("even6 done count", 32'(dedge6.size()), 32'd1);
      cmp("even6 done cycle", (dedge6.size() > 0) ? 32'(dedge6[0]) : 32'hFFFF_FFFF, 32'(last_edge + 2));
      cmp("even6 done standalone",
          (wedge6.size() == 4 && dedge6.size() > 0) ? 32'(wedge6[3] != dedge6[0]) : 32'd0, 32'd1);

      // Signed compare: most-negative background with a single -1.
      for (int i = 0; i < 64; i++) pix[i] = 23'h400000;
      pix[6] = 23'h7FFFFF;
      clear_logs();
      add4(32'h7FFFFF, 32'h400000, 32'h400000, 32'h400000);
      feed_frame(5, 5, 5, 0);
      drain();
      check_list("signed5", 5);

      // Reset mid-frame, then two back-to-back frames.
      ramp(5);
      clear_logs();
      for (int i = 0; i < 7; i++) step(5, 1'b1, DW'(i));
      pulse_reset();
      add4(12, 14, 22, 24);
      add4(12, 14, 22, 24);
      feed_frame(5, 5, 5, 0);
      feed_frame(5, 5, 5, 0);
      drain();
      check_list("b2b5", 5);
      cmp("b2b5 done count", 32'(dedge5.size()), 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
